// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
// Walks FETCH/DCD/EXE/MEM/WB (plus MDWAIT for multiply/divide) and drives
// the datapath enables and selects for the current state.
// Optional feature macro: MULDIV_EN adds mult/multu/div/divu, mfhi/mflo,
// the MDWAIT state and its cycle counter. Without it those instructions
// decode as illegal and MDStart/MDBusy are held at 0.
module mc_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int STATE_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWr,
  output logic [1:0]         NPCOp,
  output logic               IRWr,
  output logic               RFWr,
  output logic               DMWr,
  output logic [1:0]         ExtOp,
  output logic [3:0]         ALUOp,
  output logic               BSel,
  output logic [1:0]         A3Sel,
  output logic [1:0]         WDSel,
  output logic               MDStart,
  output logic               MDBusy,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DCD    = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
`ifdef MULDIV_EN
    ,
    MDWAIT = 3'd5
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_ILL,
    C_RALU,
    C_IALU,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_JR,
    C_MD
  } cls_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  state_t     state_q;
  state_t     state_d;
  cls_t       cls;
  logic [3:0] dec_alu;
  logic [1:0] dec_ext;
  logic       dec_bsel;
  logic [1:0] dec_wd;

  logic       pcwr_c;
  logic [1:0] npc_c;
  logic       irwr_c;
  logic       rfwr_c;
  logic       dmwr_c;
  logic [1:0] ext_c;
  logic [3:0] alu_c;
  logic       bsel_c;
  logic [1:0] a3_c;
  logic [1:0] wd_c;
  logic       ill_c;

`ifdef MULDIV_EN
  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);
  logic [7:0] md_cnt;
  logic       mdstart_c;
  logic       mdbusy_c;
`endif

  // Classify the instruction held in the IR and pick its ALU/extension/write-back settings
  always_comb begin
    cls      = C_ILL;
    dec_alu  = ALU_ADD;
    dec_ext  = 2'b00;
    dec_bsel = 1'b0;
    dec_wd   = 2'b00;
    case (op)
      6'h00: begin
        case (funct)
          6'h21: begin cls = C_RALU; dec_alu = ALU_ADD; end
          6'h23: begin cls = C_RALU; dec_alu = ALU_SUB; end
          6'h24: begin cls = C_RALU; dec_alu = ALU_AND; end
          6'h25: begin cls = C_RALU; dec_alu = ALU_OR;  end
          6'h2A: begin cls = C_RALU; dec_alu = ALU_SLT; end
          6'h00: begin cls = C_RALU; dec_alu = ALU_SLL; end
          6'h02: begin cls = C_RALU; dec_alu = ALU_SRL; end
          6'h08: cls = C_JR;
`ifdef MULDIV_EN
          6'h18, 6'h19, 6'h1A, 6'h1B: cls = C_MD;
          6'h10, 6'h12: begin cls = C_RALU; dec_wd = 2'b11; end
`endif
          default: cls = C_ILL;
        endcase
      end
      6'h0D: begin cls = C_IALU; dec_alu = ALU_OR;  dec_ext = 2'b00; dec_bsel = 1'b1; end
      6'h09: begin cls = C_IALU; dec_alu = ALU_ADD; dec_ext = 2'b01; dec_bsel = 1'b1; end
      6'h0A: begin cls = C_IALU; dec_alu = ALU_SLT; dec_ext = 2'b01; dec_bsel = 1'b1; end
      6'h0F: begin cls = C_IALU; dec_alu = ALU_ADD; dec_ext = 2'b10; dec_bsel = 1'b1; end
      6'h23: begin cls = C_LW;   dec_alu = ALU_ADD; dec_ext = 2'b01; dec_bsel = 1'b1; dec_wd = 2'b01; end
      6'h2B: begin cls = C_SW;   dec_alu = ALU_ADD; dec_ext = 2'b01; dec_bsel = 1'b1; end
      6'h04: begin cls = C_BEQ;  dec_alu = ALU_SUB; end
      6'h05: begin cls = C_BNE;  dec_alu = ALU_SUB; end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

  // Next-state and per-state control outputs; anything not set in a state stays 0
  always_comb begin
    state_d = state_q;
    pcwr_c  = 1'b0;
    npc_c   = 2'b00;
    irwr_c  = 1'b0;
    rfwr_c  = 1'b0;
    dmwr_c  = 1'b0;
    ext_c   = 2'b00;
    alu_c   = 4'd0;
    bsel_c  = 1'b0;
    a3_c    = 2'b00;
    wd_c    = 2'b00;
    ill_c   = 1'b0;
`ifdef MULDIV_EN
    mdstart_c = 1'b0;
    mdbusy_c  = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        irwr_c  = 1'b1;
        pcwr_c  = 1'b1;
        state_d = DCD;
      end
      DCD: begin
        case (cls)
          C_J: begin
            pcwr_c  = 1'b1;
            npc_c   = 2'b10;
            state_d = FETCH;
          end
          C_JAL: begin
            pcwr_c  = 1'b1;
            npc_c   = 2'b10;
            rfwr_c  = 1'b1;
            a3_c    = 2'b10;
            wd_c    = 2'b10;
            state_d = FETCH;
          end
          C_JR: begin
            pcwr_c  = 1'b1;
            npc_c   = 2'b11;
            state_d = FETCH;
          end
          C_ILL: begin
            ill_c   = 1'b1;
            state_d = FETCH;
          end
          default: state_d = EXE;
        endcase
      end
      EXE: begin
        alu_c  = dec_alu;
        ext_c  = dec_ext;
        bsel_c = dec_bsel;
        case (cls)
          C_BEQ: begin
            pcwr_c  = zero;
            npc_c   = 2'b01;
            state_d = FETCH;
          end
          C_BNE: begin
            pcwr_c  = ~zero;
            npc_c   = 2'b01;
            state_d = FETCH;
          end
          C_LW, C_SW: state_d = MEM;
`ifdef MULDIV_EN
          C_MD: begin
            mdstart_c = 1'b1;
            state_d   = MDWAIT;
          end
`endif
          default: state_d = WB;
        endcase
      end
      MEM: begin
        if (cls == C_SW) begin
          dmwr_c  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        rfwr_c  = 1'b1;
        wd_c    = dec_wd;
        a3_c    = (cls == C_RALU) ? 2'b01 : 2'b00;
        state_d = FETCH;
      end
`ifdef MULDIV_EN
      MDWAIT: begin
        mdbusy_c = 1'b1;
        if (md_cnt == 8'd0) state_d = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

`ifdef MULDIV_EN
  // MDWAIT down-counter: loaded when the start pulse fires, leaves MDWAIT on reaching 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt <= 8'd0;
    end else if (state_q == EXE && cls == C_MD) begin
      md_cnt <= MD_LOAD;
    end else if (state_q == MDWAIT && md_cnt != 8'd0) begin
      md_cnt <= md_cnt - 8'd1;
    end
  end

  assign MDStart = mdstart_c & ~rst;
  assign MDBusy  = mdbusy_c;
`else
  assign MDStart = 1'b0;
  assign MDBusy  = 1'b0;
`endif

  // Write enables and pulses are masked while reset is held, since FETCH would otherwise drive them
  assign PCWr    = pcwr_c & ~rst;
  assign IRWr    = irwr_c & ~rst;
  assign RFWr    = rfwr_c & ~rst;
  assign DMWr    = dmwr_c & ~rst;
  assign illegal = ill_c & ~rst;
  assign NPCOp   = npc_c;
  assign ExtOp   = ext_c;
  assign ALUOp   = alu_c;
  assign BSel    = bsel_c;
  assign A3Sel   = a3_c;
  assign WDSel   = wd_c;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized and directed checks of mc_ctrl against a
// cycle-list reference model built from the instruction rules.
module tb_mc_ctrl;

  localparam int MD_CYC = 4;
`ifdef MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic [1:0] NPCOp;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic [1:0] ExtOp;
  logic [3:0] ALUOp;
  logic       BSel;
  logic [1:0] A3Sel;
  logic [1:0] WDSel;
  logic       MDStart;
  logic       MDBusy;
  logic       illegal;
  logic [2:0] state;

  int testCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [1:0] npc;
    logic       irwr;
    logic       rfwr;
    logic       dmwr;
    logic [1:0] ext;
    logic [3:0] alu;
    logic       bsel;
    logic [1:0] a3;
    logic [1:0] wd;
    logic       mds;
    logic       mdb;
    logic       ill;
  } exp_t;

  exp_t expQ[$];

  logic [11:0] instTab [0:23] = '{
    12'h021, 12'h023, 12'h024, 12'h025, 12'h02A, 12'h000, 12'h002, 12'h008,
    12'h018, 12'h019, 12'h01A, 12'h01B, 12'h010, 12'h012,
    {6'h0D, 6'h00}, {6'h09, 6'h00}, {6'h0A, 6'h00}, {6'h0F, 6'h00},
    {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
    {6'h02, 6'h00}, {6'h03, 6'h00}
  };

  mc_ctrl #(.MD_CYCLES(MD_CYC), .STATE_W(3)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .ExtOp(ExtOp), .ALUOp(ALUOp), .BSel(BSel), .A3Sel(A3Sel), .WDSel(WDSel),
    .MDStart(MDStart), .MDBusy(MDBusy), .illegal(illegal), .state(state)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    testCount++;
    if (got !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.st = state;     o.pcwr = PCWr;  o.npc = NPCOp;   o.irwr = IRWr;
    o.rfwr = RFWr;    o.dmwr = DMWr;  o.ext = ExtOp;   o.alu = ALUOp;
    o.bsel = BSel;    o.a3 = A3Sel;   o.wd = WDSel;    o.mds = MDStart;
    o.mdb = MDBusy;   o.ill = illegal;
    return o;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  // Instruction mnemonic from the op/funct fields
  function automatic string kindOf(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: begin
        case (f)
          6'h21: return "addu";
          6'h23: return "subu";
          6'h24: return "and";
          6'h25: return "or";
          6'h2A: return "slt";
          6'h00: return "sll";
          6'h02: return "srl";
          6'h08: return "jr";
          6'h18, 6'h19, 6'h1A, 6'h1B: return MD_EN ? "md" : "ill";
          6'h10, 6'h12: return MD_EN ? "mf" : "ill";
          default: return "ill";
        endcase
      end
      6'h0D: return "ori";
      6'h09: return "addiu";
      6'h0A: return "slti";
      6'h0F: return "lui";
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h05: return "bne";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "ill";
    endcase
  endfunction

  // Build the expected per-cycle outputs of one instruction into expQ
  task automatic buildModel(input string name, input logic z);
    exp_t e;
    expQ.delete();
    e = blank(3'd0); e.pcwr = 1'b1; e.irwr = 1'b1; expQ.push_back(e);
    e = blank(3'd1);
    if (name == "j")   begin e.pcwr = 1'b1; e.npc = 2'd2; expQ.push_back(e); return; end
    if (name == "jal") begin e.pcwr = 1'b1; e.npc = 2'd2; e.rfwr = 1'b1; e.a3 = 2'd2; e.wd = 2'd2; expQ.push_back(e); return; end
    if (name == "jr")  begin e.pcwr = 1'b1; e.npc = 2'd3; expQ.push_back(e); return; end
    if (name == "ill") begin e.ill = 1'b1; expQ.push_back(e); return; end
    expQ.push_back(e);
    e = blank(3'd2);
    case (name)
      "subu":  e.alu = 4'd1;
      "and":   e.alu = 4'd2;
      "or":    e.alu = 4'd3;
      "slt":   e.alu = 4'd4;
      "sll":   e.alu = 4'd5;
      "srl":   e.alu = 4'd6;
      "ori":   begin e.alu = 4'd3; e.bsel = 1'b1; e.ext = 2'd0; end
      "addiu": begin e.alu = 4'd0; e.bsel = 1'b1; e.ext = 2'd1; end
      "slti":  begin e.alu = 4'd4; e.bsel = 1'b1; e.ext = 2'd1; end
      "lui":   begin e.alu = 4'd0; e.bsel = 1'b1; e.ext = 2'd2; end
      "lw", "sw": begin e.alu = 4'd0; e.bsel = 1'b1; e.ext = 2'd1; end
      "beq":   begin e.alu = 4'd1; e.npc = 2'd1; e.pcwr = z; end
      "bne":   begin e.alu = 4'd1; e.npc = 2'd1; e.pcwr = ~z; end
      "md":    e.mds = 1'b1;
      default: e.alu = 4'd0;
    endcase
    expQ.push_back(e);
    if (name == "beq" || name == "bne") return;
    if (name == "md") begin
      for (int k = 0; k < MD_CYC; k++) begin
        e = blank(3'd5); e.mdb = 1'b1; expQ.push_back(e);
      end
      return;
    end
    if (name == "lw" || name == "sw") begin
      e = blank(3'd3); e.dmwr = (name == "sw"); expQ.push_back(e);
      if (name == "sw") return;
    end
    e = blank(3'd4);
    e.rfwr = 1'b1;
    e.a3 = (name == "lw" || name == "ori" || name == "addiu" || name == "slti" || name == "lui") ? 2'd0 : 2'd1;
    e.wd = (name == "lw") ? 2'd1 : (name == "mf") ? 2'd3 : 2'd0;
    expQ.push_back(e);
  endtask

  // Run one instruction from FETCH back to FETCH, checking every cycle
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
    string name;
    op = o; funct = f; zero = z;
    name = kindOf(o, f);
    buildModel(name, z);
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s op%h fn%h cyc%0d", name, o, f, i), 32'(observe()), 32'(expQ[i]));
      @(posedge clk);
      #1;
    end
  endtask

  // Start an instruction and assert reset during cycle index stopAt, then recover
  task automatic abortWithReset(input logic [5:0] o, input logic [5:0] f, input int stopAt);
    string name;
    op = o; funct = f; zero = 1'b0;
    name = kindOf(o, f);
    buildModel(name, 1'b0);
    for (int i = 0; i <= stopAt; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s pre-reset cyc%0d", name, i), 32'(observe()), 32'(expQ[i]));
      if (i < stopAt) begin
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b1;
    #1;
    checkOutput($sformatf("%s reset abort", name), 32'(observe()), 32'(blank(3'd0)));
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s reset hold", name), 32'(observe()), 32'(blank(3'd0)));
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] pick;
    rst = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset outputs", 32'(observe()), 32'(blank(3'd0)));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // addu, lw, sw, beq taken/not taken, bne, jal, j, jr, illegal
    applyStimulus(6'h00, 6'h21, 1'b0);
    applyStimulus(6'h23, 6'h00, 1'b0);
    applyStimulus(6'h2B, 6'h00, 1'b0);
    applyStimulus(6'h04, 6'h00, 1'b1);
    applyStimulus(6'h04, 6'h00, 1'b0);
    applyStimulus(6'h05, 6'h00, 1'b0);
    applyStimulus(6'h03, 6'h00, 1'b0);
    applyStimulus(6'h02, 6'h00, 1'b0);
    applyStimulus(6'h00, 6'h08, 1'b0);
    applyStimulus(6'h3F, 6'h00, 1'b0);
    applyStimulus(6'h0F, 6'h00, 1'b0);

    // multiply/divide group: full run, then reset in the 2nd MDWAIT cycle
    applyStimulus(6'h00, 6'h18, 1'b0);
    applyStimulus(6'h00, 6'h10, 1'b0);
`ifdef MULDIV_EN
    abortWithReset(6'h00, 6'h18, 4);
    applyStimulus(6'h3F, 6'h00, 1'b0);
`endif

    // reset in the middle of lw EXE
    abortWithReset(6'h23, 6'h00, 2);
    applyStimulus(6'h00, 6'h25, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      end else begin
        pick = instTab[$urandom_range(0, 23)];
        applyStimulus(pick[11:6], pick[5:0], 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 32, giving the number of MDWAIT cycles per multiply/divide (legal range 1..255).
REQ-002 The block SHALL have parameter STATE_W, default 3, giving the width of the state output.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port op, input, 6 bits: instruction[31:26] from the instruction register.
REQ-006 The block SHALL have port funct, input, 6 bits: instruction[5:0].
REQ-007 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 The block SHALL have port PCWr, output, 1 bit: PC load enable.
REQ-009 The block SHALL have port NPCOp, output, 2 bits: next-PC source (00 PC+4, 01 branch, 10 imm26 jump, 11 register jump).
REQ-010 The block SHALL have port IRWr, output, 1 bit: instruction register load.
REQ-011 The block SHALL have port RFWr, output, 1 bit: register file write enable.
REQ-012 The block SHALL have port DMWr, output, 1 bit: data memory write enable.
REQ-013 The block SHALL have port ExtOp, output, 2 bits: extension mode (00 zero-extend, 01 sign-extend, 10 lui high).
REQ-014 The block SHALL have port ALUOp, output, 4 bits: ALU operation (0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl).
REQ-015 The block SHALL have port BSel, output, 1 bit: ALU operand B source (0 register, 1 extended immediate).
REQ-016 The block SHALL have port A3Sel, output, 2 bits: destination register (00 rt, 01 rd, 10 $31).
REQ-017 The block SHALL have port WDSel, output, 2 bits: write-back data (00 ALU, 01 DM, 10 PC, 11 HI/LO).
REQ-018 The block SHALL have port MDStart, output, 1 bit: one-cycle multiply/divide start pulse.
REQ-019 The block SHALL have port MDBusy, output, 1 bit: high while in MDWAIT.
REQ-020 The block SHALL have port illegal, output, 1 bit: one-cycle pulse on an undecodable instruction.
REQ-021 The block SHALL have port state, output, STATE_W bits: current FSM state.

Function
REQ-022 States SHALL be encoded FETCH=0, DCD=1, EXE=2, MEM=3, WB=4, MDWAIT=5.
REQ-023 In FETCH the block SHALL assert IRWr=1, PCWr=1 and NPCOp=00, and SHALL move to DCD.
REQ-024 In DCD, j SHALL assert PCWr with NPCOp=10; jal SHALL do the same and also assert RFWr with A3Sel=10 and WDSel=10 (PC, already incremented); jr SHALL assert PCWr with NPCOp=11; all three SHALL then go to FETCH (2 cycles per instruction).
REQ-025 R-type addu/subu/and/or/slt/sll/srl SHALL take the path DCD->EXE->WB with BSel=0, and WB SHALL assert RFWr with A3Sel=01 and WDSel=00 (4 cycles).
REQ-026 ori/addiu/slti/lui SHALL take the path DCD->EXE->WB with BSel=1, ExtOp 00/01/01/10 respectively, and WB SHALL assert RFWr with A3Sel=00 (4 cycles).
REQ-027 lw SHALL take the path EXE->MEM->WB with add and ExtOp=01, and WB SHALL use WDSel=01 (5 cycles).
REQ-028 sw SHALL take the path EXE->MEM, MEM SHALL assert DMWr=1, and the next state SHALL be FETCH (4 cycles).
REQ-029 beq/bne SHALL use ALUOp=sub in EXE, with PCWr=(beq&zero)|(bne&~zero) and NPCOp=01, and SHALL then go to FETCH (3 cycles).
REQ-030 An unknown op/funct SHALL pulse illegal in DCD, SHALL assert no write enable, and SHALL return to FETCH.
REQ-031 RFWr, DMWr and PCWr SHALL each be high for at most one cycle per instruction, except that PCWr is also asserted in FETCH; every output not explicitly driven in a state SHALL be 0.

Reset
REQ-032 While rst=1 the block SHALL force state=FETCH, clear the MDWAIT counter to 0, and hold PCWr, IRWr, RFWr, DMWr, MDStart and illegal at 0 regardless of state.
REQ-033 Asserting rst in any state, including mid-MDWAIT, SHALL abort the instruction, and the first edge after deassertion SHALL perform FETCH.

Configuration
REQ-034 With MULDIV_EN defined, mult/multu/div/divu (funct 0x18-0x1B) SHALL pulse MDStart in EXE and then enter MDWAIT.
REQ-035 With MULDIV_EN defined, MDWAIT SHALL hold MDBusy=1 for exactly MD_CYCLES cycles using a down-counter, and SHALL then go to FETCH.
REQ-036 With MULDIV_EN defined, mfhi/mflo (0x10/0x12) SHALL behave as R-type with WDSel=11.
REQ-037 Without MULDIV_EN, those functs SHALL be illegal (REQ-030), MDStart and MDBusy SHALL be tied to 0, and the MDWAIT state and counter SHALL be absent.

Verification
REQ-038 The bench SHALL check reset then addu: the state sequence SHALL be 0,1,2,4,0, with RFWr=1, A3Sel=01 and WDSel=00 only in WB.
REQ-039 The bench SHALL check lw then sw: lw SHALL walk 0,1,2,3,4 with WDSel=01; sw SHALL walk 0,1,2,3 with DMWr=1 in MEM and RFWr never set.
REQ-040 The bench SHALL check beq with zero=1, then with zero=0: PCWr=1 and NPCOp=01 in EXE for the first; PCWr=0 in EXE for the second.
REQ-041 The bench SHALL check jal: in DCD, PCWr=1, NPCOp=10, RFWr=1, A3Sel=10 and WDSel=10; the next state SHALL be FETCH.
REQ-042 The bench SHALL check, with MULDIV_EN and MD_CYCLES=4, that mult pulses MDStart once, that MDBusy stays high for exactly 4 cycles, and that the FSM then returns to FETCH; with rst asserted at the 2nd MDWAIT cycle, MDBusy SHALL fall immediately and state SHALL be 0.
REQ-043 The bench SHALL check op=0x3F: illegal SHALL pulse once in DCD, no write enable SHALL assert, and the FSM SHALL return to FETCH.
